// File: rtl/deadtime_gen.sv
// Dead-time generator: turns the per-leg phase commands drv_i[1:0] into
// complementary high/low gate commands with a programmable all-off gap on
// every transition, plus a sticky fault shutdown and zero-cycle kill.

// Per-leg state machine. The gate registers hold the decode of the state one
// cycle later, so an edge that moves the FSM into a dead-time window turns the
// old gate off on the following edge. With that alignment the off-gap between
// gates is exactly DT cycles.
module deadtime_leg #(
    parameter int DEADTIME_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     kill_i,
    input  logic                     drv_i,
    input  logic [DEADTIME_BITS-1:0] dt_m1_i,   // effective dead time minus one
    output logic                     hi_o,
    output logic                     lo_o,
    output logic                     in_dt_o
);

    typedef enum logic [2:0] {
        SAFE  = 3'd0,
        LO_ON = 3'd1,
        DT_LH = 3'd2,
        HI_ON = 3'd3,
        DT_HL = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [DEADTIME_BITS-1:0] cnt_q, cnt_d;
    logic                     hi_q, hi_d;
    logic                     lo_q, lo_d;

    // State, counter and gate registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SAFE;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next state: kill has top priority; a reversal inside a window restarts
    // the full dead time in the opposite direction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill_i) begin
            state_d = SAFE;
        end else begin
            case (state_q)
                SAFE: begin
                    state_d = drv_i ? DT_LH : DT_HL;
                    cnt_d   = dt_m1_i;
                end
                LO_ON: begin
                    if (drv_i) begin
                        state_d = DT_LH;
                        cnt_d   = dt_m1_i;
                    end
                end
                HI_ON: begin
                    if (!drv_i) begin
                        state_d = DT_HL;
                        cnt_d   = dt_m1_i;
                    end
                end
                DT_LH: begin
                    if (!drv_i) begin
                        state_d = DT_HL;
                        cnt_d   = dt_m1_i;
                    end else if (cnt_q == '0) begin
                        state_d = HI_ON;
                    end else begin
                        cnt_d = cnt_q - DEADTIME_BITS'(1);
                    end
                end
                DT_HL: begin
                    if (drv_i) begin
                        state_d = DT_LH;
                        cnt_d   = dt_m1_i;
                    end else if (cnt_q == '0) begin
                        state_d = LO_ON;
                    end else begin
                        cnt_d = cnt_q - DEADTIME_BITS'(1);
                    end
                end
                default: state_d = SAFE;
            endcase
        end
    end

    // Gate decode; forced off under kill so a short enable dip leaves no stale
    // on-value in the gate register when the kill releases.
    always_comb begin
        hi_d = 1'b0;
        lo_d = 1'b0;
        if (!kill_i) begin
            case (state_q)
                LO_ON:   lo_d = 1'b1;
                HI_ON:   hi_d = 1'b1;
                default: ;
            endcase
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign in_dt_o = (state_q == DT_LH) || (state_q == DT_HL);

endmodule

module deadtime_gen #(
    parameter int DEADTIME_BITS = 8,
    parameter int DT_DEFAULT    = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [1:0]               drv_i,
    input  logic [DEADTIME_BITS-1:0] dt_ticks_i,
    input  logic                     dt_load_i,
    input  logic                     fault_i,
    input  logic                     fault_clr_i,
    output logic [1:0]               gate_hi_o,
    output logic [1:0]               gate_lo_o,
    output logic                     flt_latched_o,
    output logic                     dt_pending_o
);

    localparam int                       NUM_LEGS = 2;
    localparam logic [DEADTIME_BITS-1:0] DT_RST   = DEADTIME_BITS'(DT_DEFAULT);

    logic [DEADTIME_BITS-1:0] dt_cur_q, dt_cur_d;
    logic [DEADTIME_BITS-1:0] dt_shadow_q, dt_shadow_d;
    logic                     dt_pend_q, dt_pend_d;
    logic                     flt_q, flt_d;

    logic [DEADTIME_BITS-1:0] dt_eff;
    logic [DEADTIME_BITS-1:0] dt_m1;
    logic                     kill;
    logic [NUM_LEGS-1:0]      leg_hi, leg_lo, leg_in_dt;
    logic                     any_dt;

    // A programmed zero still gives one cycle of all-off
    assign dt_eff = (dt_cur_q == '0) ? DEADTIME_BITS'(1) : dt_cur_q;
    assign dt_m1  = dt_eff - DEADTIME_BITS'(1);
    assign kill   = ~en_i | fault_i | flt_q;
    assign any_dt = |leg_in_dt;

    for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
        deadtime_leg #(
            .DEADTIME_BITS(DEADTIME_BITS)
        ) u_leg (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .kill_i  (kill),
            .drv_i   (drv_i[g]),
            .dt_m1_i (dt_m1),
            .hi_o    (leg_hi[g]),
            .lo_o    (leg_lo[g]),
            .in_dt_o (leg_in_dt[g])
        );
    end

    // Fault latch: set wins over clear
    always_comb begin
        flt_d = flt_q;
        if (fault_i) begin
            flt_d = 1'b1;
        end else if (fault_clr_i) begin
            flt_d = 1'b0;
        end
    end

    // Dead-time update: never change dt_cur under a running window; the last
    // load seen while a window runs is parked and applied once all legs are out.
    always_comb begin
        dt_cur_d    = dt_cur_q;
        dt_shadow_d = dt_shadow_q;
        dt_pend_d   = dt_pend_q;
        if (dt_load_i) begin
            if (any_dt) begin
                dt_shadow_d = dt_ticks_i;
                dt_pend_d   = 1'b1;
            end else begin
                dt_cur_d  = dt_ticks_i;
                dt_pend_d = 1'b0;
            end
        end else if (dt_pend_q && !any_dt) begin
            dt_cur_d  = dt_shadow_q;
            dt_pend_d = 1'b0;
        end
    end

    // Shared configuration and fault registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dt_cur_q    <= DT_RST;
            dt_shadow_q <= '0;
            dt_pend_q   <= 1'b0;
            flt_q       <= 1'b0;
        end else begin
            dt_cur_q    <= dt_cur_d;
            dt_shadow_q <= dt_shadow_d;
            dt_pend_q   <= dt_pend_d;
            flt_q       <= flt_d;
        end
    end

    // Zero-cycle kill on top of the registered gates
    assign gate_hi_o     = leg_hi & {NUM_LEGS{~kill}};
    assign gate_lo_o     = leg_lo & {NUM_LEGS{~kill}};
    assign flt_latched_o = flt_q;
    assign dt_pending_o  = dt_pend_q;

endmodule

// File: tb/tb_deadtime_gen.sv
// Bench for deadtime_gen: a stimulus table for power-up and transitions, then
// hand-written sequences for fault, deferred dt_load, zero dead time and reset.
module tb_deadtime_gen;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic [1:0] drv_i;
    logic [7:0] dt_ticks_i;
    logic       dt_load_i;
    logic       fault_i;
    logic       fault_clr_i;
    logic [1:0] gate_hi_o;
    logic [1:0] gate_lo_o;
    logic       flt_latched_o;
    logic       dt_pending_o;

    always #5 clk_i = ~clk_i;

    deadtime_gen #(.DEADTIME_BITS(8), .DT_DEFAULT(10)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .drv_i         (drv_i),
        .dt_ticks_i    (dt_ticks_i),
        .dt_load_i     (dt_load_i),
        .fault_i       (fault_i),
        .fault_clr_i   (fault_clr_i),
        .gate_hi_o     (gate_hi_o),
        .gate_lo_o     (gate_lo_o),
        .flt_latched_o (flt_latched_o),
        .dt_pending_o  (dt_pending_o)
    );

    typedef struct {
        logic       en;
        logic [1:0] drv;
        logic       flt;
        logic       clr;
        logic       ld;
        logic [7:0] dt;
        logic [1:0] hi;
        logic [1:0] lo;
        logic       fl;
        logic       pend;
    } vec_t;

    typedef struct {
        logic [1:0] hi;
        logic [1:0] lo;
        logic       fl;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic en, logic [1:0] drv, logic flt, logic clr,
                                logic ld, logic [7:0] dt, logic [1:0] hi,
                                logic [1:0] lo, logic fl, logic pend);
        vec_t v;
        v.en = en; v.drv = drv; v.flt = flt; v.clr = clr; v.ld = ld; v.dt = dt;
        v.hi = hi; v.lo = lo; v.fl = fl; v.pend = pend;
        return v;
    endfunction

    task automatic chk(string nm, int idx, string fld, logic [1:0] act, logic [1:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s[%0d] %s: got %b, want %b", nm, idx, fld, act, want);
        end
    endtask

    // Pop the oldest expectation and compare against the DUT outputs
    task automatic compare(string nm, int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s[%0d] scoreboard: got empty queue, want entry", nm, idx);
        end else begin
            e = exp_q.pop_front();
            chk(nm, idx, "gate_hi", gate_hi_o, e.hi);
            chk(nm, idx, "gate_lo", gate_lo_o, e.lo);
            chk(nm, idx, "flt_latched", {1'b0, flt_latched_o}, {1'b0, e.fl});
            chk(nm, idx, "dt_pending", {1'b0, dt_pending_o}, {1'b0, e.pend});
            chk(nm, idx, "overlap", gate_hi_o & gate_lo_o, 2'b00);
        end
    endtask

    // Drive a vector, queue its expectation, then sample 1 time unit after
    // the next rising edge (tk=1) or after a settle with no edge (tk=0)
    task automatic apply(vec_t v, string nm, int idx, bit tk);
        exp_t e;
        en_i = v.en; drv_i = v.drv; fault_i = v.flt; fault_clr_i = v.clr;
        dt_load_i = v.ld; dt_ticks_i = v.dt;
        e.hi = v.hi; e.lo = v.lo; e.fl = v.fl; e.pend = v.pend;
        exp_q.push_back(e);
        if (tk) begin
            @(posedge clk_i);
            #1;
        end else begin
            #1;
        end
        compare(nm, idx);
    endtask

    // Power-up from SAFE with drv=00: low gates on after DT_DEFAULT all-off cycles
    task automatic startup_10(string nm);
        for (int k = 0; k < 12; k++)
            apply(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, (k == 11) ? 2'b11 : 2'b00, 0, 0), nm, k, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- table: power-up, dt=5 low->high, and a short pulse inside DT_LH
        for (int k = 0; k < 12; k++)
            tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, (k == 11) ? 2'b11 : 2'b00, 0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 1, 8'd5, 2'b00, 2'b11, 0, 0));
        for (int j = 0; j < 7; j++)
            tbl.push_back(mk(1, 2'b01, 0, 0, 0, 0, (j == 6) ? 2'b01 : 2'b00,
                             (j == 0) ? 2'b11 : 2'b10, 0, 0));
        for (int j = 0; j < 7; j++)
            tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, (j == 0) ? 2'b01 : 2'b00,
                             (j == 6) ? 2'b11 : 2'b10, 0, 0));
        for (int j = 0; j < 9; j++)
            tbl.push_back(mk(1, (j < 2) ? 2'b01 : 2'b00, 0, 0, 0, 0, 2'b00,
                             (j == 0 || j == 8) ? 2'b11 : 2'b10, 0, 0));

        // ---- reset state
        rst_ni = 1'b0;
        apply(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "reset", 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        apply(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "idle_en0", 0, 1);

        foreach (tbl[i]) apply(tbl[i], "table", i, 1);

        // ---- fault: leg0 to HI_ON, then kill in the same cycle, sticky latch
        for (int j = 0; j < 7; j++)
            apply(mk(1, 2'b01, 0, 0, 0, 0, (j == 6) ? 2'b01 : 2'b00,
                     (j == 0) ? 2'b11 : 2'b10, 0, 0), "to_hi", j, 1);
        apply(mk(1, 2'b01, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0), "fault_comb", 0, 0);
        apply(mk(1, 2'b01, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0), "fault_latch", 0, 1);
        apply(mk(1, 2'b01, 1, 1, 0, 0, 2'b00, 2'b00, 1, 0), "clr_while_fault", 0, 1);
        apply(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0), "sticky", 0, 1);
        apply(mk(1, 2'b01, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0), "fault_clear", 0, 1);
        for (int j = 0; j < 7; j++)
            apply(mk(1, 2'b01, 0, 0, 0, 0, (j == 6) ? 2'b01 : 2'b00,
                     (j == 6) ? 2'b10 : 2'b00, 0, 0), "restart", j, 1);

        // ---- deferred load: dt=8 window on leg0, loads of 6 then 3 during it
        apply(mk(1, 2'b01, 0, 0, 1, 8'd8, 2'b01, 2'b10, 0, 0), "load8", 0, 1);
        apply(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0), "win8", 0, 1);
        apply(mk(1, 2'b00, 0, 0, 1, 8'd6, 2'b00, 2'b10, 0, 1), "win8", 1, 1);
        apply(mk(1, 2'b00, 0, 0, 1, 8'd3, 2'b00, 2'b10, 0, 1), "win8", 2, 1);
        for (int j = 3; j < 9; j++)
            apply(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 0, 1), "win8", j, 1);
        apply(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0), "win8", 9, 1);
        for (int j = 0; j < 5; j++)
            apply(mk(1, 2'b01, 0, 0, 0, 0, (j == 4) ? 2'b01 : 2'b00,
                     (j == 0) ? 2'b11 : 2'b10, 0, 0), "win3", j, 1);

        // ---- dt=0 behaves as a single all-off cycle
        apply(mk(1, 2'b01, 0, 0, 1, 8'd0, 2'b01, 2'b10, 0, 0), "load0", 0, 1);
        apply(mk(1, 2'b00, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0), "win1", 0, 1);
        apply(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0), "win1", 1, 1);
        apply(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0), "win1", 2, 1);

        // ---- reset in the middle of a window, then dt_cur back to default
        apply(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0), "pre_rst", 0, 1);
        rst_ni = 1'b0;
        apply(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "rst_mid_dt", 0, 0);
        apply(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "rst_hold", 0, 1);
        rst_ni = 1'b1;
        startup_10("after_rst");

        // ---- enable drop: immediate off, then a full default window again
        apply(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "en_drop", 0, 0);
        apply(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), "en_low", 0, 1);
        startup_10("re_enable");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
